// File: rtl/troca_contexto.sv
// Context-switch controller: saves the preempted process PC into a per-process
// table, enters the OS handler, and restores a user PC on an OS dispatch.
module troca_contexto #(
    parameter int          N_PROC   = 8,
    parameter logic [31:0] SO_ENTRY = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        swap_SO,
    input  logic [31:0] ultimo_pc,
    input  logic        despacho,
    input  logic [4:0]  desp_id,
    input  logic        ini_we,
    input  logic [4:0]  ini_id,
    input  logic [31:0] ini_pc,
    input  logic [4:0]  cons_id,
    output logic [31:0] cons_pc,
    output logic [4:0]  idProc,
    output logic [31:0] pc_novo,
    output logic        carrega_pc,
    output logic        pausa_PC,
    output logic        erro
);

    localparam logic [5:0] NP = 6'(N_PROC);

    typedef enum logic [1:0] {EXEC, SALVA, ENTRA_SO, RESTAURA} estado_t;

    estado_t     state_q;
    logic [4:0]  idProc_q, id_salvo_q, desp_q;
    logic [31:0] pc_novo_q, pc_salvo_q;
    logic        carrega_q, pausa_q, erro_q, swap_ant_q;
    logic [31:0] tabela_q [N_PROC];
    logic [31:0] rest_pc;
    logic        swap_edge, desp_ok;

    assign swap_edge = swap_SO & ~swap_ant_q;
    assign desp_ok   = (desp_id != 5'd0) && ({1'b0, desp_id} < NP);

    // Index-match muxes keep the 5-bit ids independent of the table depth.
    always_comb begin
        cons_pc = 32'd0;
        rest_pc = 32'd0;
        for (int i = 0; i < N_PROC; i++) begin
            if (cons_id == 5'(i)) cons_pc = tabela_q[i];
            if (desp_q  == 5'(i)) rest_pc = tabela_q[i];
        end
    end

    // The pending save takes precedence over an OS initial-PC write to the same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PROC; i++) tabela_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < N_PROC; i++) begin
                if (state_q == SALVA && id_salvo_q == 5'(i))
                    tabela_q[i] <= pc_salvo_q;
                else if (ini_we && ini_id == 5'(i))
                    tabela_q[i] <= ini_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EXEC;
            idProc_q   <= 5'd0;
            pc_novo_q  <= SO_ENTRY;
            carrega_q  <= 1'b0;
            pausa_q    <= 1'b1;
            erro_q     <= 1'b0;
            swap_ant_q <= 1'b0;
            pc_salvo_q <= 32'd0;
            id_salvo_q <= 5'd0;
            desp_q     <= 5'd0;
        end else begin
            swap_ant_q <= swap_SO;
            carrega_q  <= 1'b0;
            erro_q     <= 1'b0;
            case (state_q)
                EXEC: begin
                    if (idProc_q != 5'd0) begin
                        if (swap_edge) begin
                            pc_salvo_q <= ultimo_pc;
                            id_salvo_q <= idProc_q;
                            pausa_q    <= 1'b0;
                            state_q    <= SALVA;
                        end
                    end else if (despacho) begin
                        if (desp_ok) begin
                            desp_q  <= desp_id;
                            pausa_q <= 1'b0;
                            state_q <= RESTAURA;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end
                end
                SALVA: state_q <= ENTRA_SO;
                ENTRA_SO: begin
                    idProc_q  <= 5'd0;
                    pc_novo_q <= SO_ENTRY;
                    carrega_q <= 1'b1;
                    pausa_q   <= 1'b1;
                    state_q   <= EXEC;
                end
                RESTAURA: begin
                    idProc_q  <= desp_q;
                    pc_novo_q <= rest_pc;
                    carrega_q <= 1'b1;
                    pausa_q   <= 1'b1;
                    state_q   <= EXEC;
                end
                default: state_q <= EXEC;
            endcase
        end
    end

    assign idProc     = idProc_q;
    assign pc_novo    = pc_novo_q;
    assign carrega_pc = carrega_q;
    assign pausa_PC   = pausa_q;
    assign erro       = erro_q;

endmodule

// File: doc/troca_contexto.md
# troca_contexto

Context-switch controller sitting directly downstream of the preemption counter. It consumes the counter's `swap_SO` and `ultimo_pc`, saves the preempted process's resume PC into a per-process table and forces the PC to the OS (id 0) handler. On an OS dispatch request it restores a user process's saved PC. It drives `idProc` and `pausa_PC`, which the counter uses, and a load strobe into the PC mux.

## Interface
Parameters:
- `N_PROC`, default 8: table entries; id 0 = SO, ids 1..N_PROC-1 = user processes.
- `SO_ENTRY`, default 32'd0: PC of the OS handler.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `swap_SO`  in  1  preemption request level from the counter.
- `ultimo_pc`  in  32  resume PC of the preempted process, valid while `swap_SO`=1.
- `despacho`  in  1  one-cycle OS request to run process `desp_id`.
- `desp_id`  in  5  process to dispatch.
- `ini_we`  in  1  OS write of an initial PC into the table.
- `ini_id`  in  5  table index for `ini_we`.
- `ini_pc`  in  32  value for `ini_we`.
- `cons_id`  in  5  table read index.
- `cons_pc`  out  32  combinational `tabela[cons_id]`; 0 if `cons_id`≥N_PROC.
- `idProc`  out  5  id of the running process.
- `pc_novo`  out  32  value the PC must load.
- `carrega_pc`  out  1  one-cycle strobe: PC loads `pc_novo`.
- `pausa_PC`  out  1  1 = PC running/counting, 0 = paused during a switch. This is the counter's polarity.
- `erro`  out  1  one-cycle pulse on an invalid dispatch.

## Operation
- States: EXEC, SALVA, ENTRA_SO, RESTAURA.
- Reset values: state EXEC, `idProc`=0, `pc_novo`=SO_ENTRY, `carrega_pc`=0, `pausa_PC`=1, `erro`=0, all table entries 0, `swap_ant`=0.
- `swap_ant` holds the previous `swap_SO` value. A request is the rising edge `swap_SO & ~swap_ant`. `swap_SO` stays high while the PC is paused, so level sensing is forbidden.
- EXEC, `idProc`≠0, swap rising edge:
  - latch `ultimo_pc` into `pc_salvo` and `idProc` into `id_salvo`;
  - set `pausa_PC`=0;
  - go to SALVA.
- SALVA: `tabela[id_salvo]` <= `pc_salvo`, then go to ENTRA_SO.
- ENTRA_SO, all in one update, then go to EXEC:
  - `idProc`<=0, `pc_novo`<=SO_ENTRY;
  - `carrega_pc`<=1, `pausa_PC`<=1.
- EXEC, `idProc`=0, `despacho`=1:
  - `desp_id` in 1..N_PROC-1: latch the id, set `pausa_PC`=0, go to RESTAURA.
  - `desp_id`=0 or ≥N_PROC: `erro`<=1 for one cycle, stay in EXEC, no other change.
- RESTAURA, all in one update, then go to EXEC:
  - `pc_novo`<=`tabela[id]`, `idProc`<=id;
  - `carrega_pc`<=1, `pausa_PC`<=1.
- Ignored events:
  - `despacho` while `idProc`≠0, or outside EXEC;
  - swap edges while `idProc`=0;
  - swap edges outside EXEC (`swap_ant` still tracks them).
- `ini_we`:
  - writes `tabela[ini_id]` in any state;
  - `ini_id`≥N_PROC is ignored; `ini_id`=0 is allowed.
  - Same-cycle SALVA write to the same index: SALVA wins.
  - Same-cycle RESTAURA read of the same index: RESTAURA reads the old value.
- Table is N_PROC × 32 registers. The `cons_pc` read is combinational.

## Timing
- The counter samples on negedge and this block on posedge, so half a cycle of setup is guaranteed.
- Preemption, swap edge sampled at posedge T:
  - T: `pausa_PC` falls.
  - T+1: table write.
  - T+2: `idProc`=0, `pc_novo`=SO_ENTRY, `carrega_pc`=1, `pausa_PC`=1.
  - T+3: `carrega_pc`=0.
  - Latency from request to load strobe: 2 cycles.
- Dispatch, sampled at posedge D:
  - D: `pausa_PC` falls.
  - D+1: `idProc`/`pc_novo` updated, `carrega_pc`=1, `pausa_PC`=1.
  - D+2: `carrega_pc`=0.
- `erro` is high for exactly the cycle after the offending posedge.
- Reset asserted mid-switch (SALVA, ENTRA_SO or RESTAURA):
  - immediately forces the reset values;
  - clears the table;
  - drops any pending save; no strobe is issued.

## Test plan
- Reset, then `ini_we` id 3 ← 32'h40, then `despacho` id 3 → 1 cycle later `idProc`=3, `pc_novo`=32'h40, `carrega_pc` high for one cycle, `pausa_PC` low for exactly one cycle.
- Running id 3: `swap_SO` rises with `ultimo_pc`=32'h4F → 2 cycles later `idProc`=0, `pc_novo`=SO_ENTRY, strobe; `cons_id`=3 gives `cons_pc`=32'h4F.
- Hold `swap_SO` high for 5 cycles → exactly one save and one strobe. Assert `swap_SO` while `idProc`=0 → no action.
- `despacho` with `desp_id`=0, then with `desp_id`=8 → `erro` pulses once for each, `idProc` stays 0, no strobe. `despacho` while id 3 runs → ignored.
- Same cycle as SALVA for id 3: `ini_we` id 3 ← 32'h99 → table holds `ultimo_pc`, not 32'h99.
- Assert `reset` during SALVA → all outputs at reset values, `cons_pc` for id 3 reads 0, no `carrega_pc`.
